// File: rtl/ps2_fifo_pkg.sv
// ps2_fifo_pkg: register offsets and bit positions shared by the PS/2
// scan-code FIFO register block.
package ps2_fifo_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_sel_e;

  // STATUS bit positions
  localparam int ST_RXRDY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_PERR    = 3;
  localparam int ST_CNT_LSB = 4;

  // CTRL bit positions
  localparam int CT_FLUSH   = 0;
  localparam int CT_IRQ_EN  = 1;

endpackage

// File: rtl/byte_sync_fifo.sv
// byte_sync_fifo: synchronous byte FIFO, 2**DEPTH_LOG2 entries, with
// simultaneous push/pop (allowed when full) and a single-cycle flush.
// Head byte is visible combinationally on dout_o.
module byte_sync_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  input  logic [7:0]            din_i,
  output logic [7:0]            dout_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  empty_o,
  output logic                  full_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = DEPTH[DEPTH_LOG2:0];

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                  do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  // a pop frees a slot in the same cycle, so a full FIFO still accepts a push
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);

  assign dout_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

  // next-state for pointers and occupancy; flush overrides everything
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // pointer/count registers, synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // storage write; contents need no reset since count gates visibility
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/ps2_scancode_fifo.sv
// ps2_scancode_fifo: buffers PS/2 scan codes and exposes DATA/STATUS/CTRL
// registers to the CPU. Optional interrupt output under PS2_FIFO_IRQ_EN;
// without it INT_N floats and CTRL bit1 reads 0.
import ps2_fifo_pkg::*;

module ps2_scancode_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] IN_DATA,
  input  logic       IN_VALID,
  input  logic       IN_PERR,
  input  logic       CS,
  input  logic       RD,
  input  logic       WR,
  input  logic [1:0] REG_SEL,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  output logic       DOUT_EN,
  output logic       INT_N
);
  logic                rd_act, wr_act, rd_end, wr_start;
  logic                rd_q, wr_q;
  reg_sel_e            rsel_q, rsel_d;
  logic                ctrl_wr, flush, pop_req, push_req, stat_clr;
  logic                ovf_set, perr_set;
  logic                ovf_q, ovf_d, perr_q, perr_d;
  logic [7:0]          head, status, ctrl_rd, rdata;
  logic [DEPTH_LOG2:0] count;
  logic [4:0]          cnt5;
  logic                empty, full, irq_en;

  assign rd_act   = CS & ~RD;
  assign wr_act   = CS & ~WR;
  // pop/clear fire when the read access ends, write acts on its first cycle
  assign rd_end   = rd_q & ~rd_act;
  assign wr_start = wr_act & ~wr_q;
  assign ctrl_wr  = wr_start & (reg_sel_e'(REG_SEL) == REG_CTRL);
  assign flush    = ctrl_wr & DIN[CT_FLUSH];
  assign pop_req  = rd_end & (rsel_q == REG_DATA);
  assign stat_clr = rd_end & (rsel_q == REG_STATUS);
  assign push_req = IN_VALID & ~IN_PERR;
  assign ovf_set  = push_req & full & ~(pop_req & ~empty);
  assign perr_set = IN_VALID & IN_PERR;

  byte_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push_i  (push_req),
    .pop_i   (pop_req),
    .flush_i (flush),
    .din_i   (IN_DATA),
    .dout_o  (head),
    .count_o (count),
    .empty_o (empty),
    .full_o  (full)
  );

  // sticky flags: flush beats set, set beats read-clear
  always_comb begin
    ovf_d  = ovf_q;
    perr_d = perr_q;
    rsel_d = rd_act ? reg_sel_e'(REG_SEL) : rsel_q;
    if (stat_clr) begin
      ovf_d  = 1'b0;
      perr_d = 1'b0;
    end
    if (ovf_set)  ovf_d  = 1'b1;
    if (perr_set) perr_d = 1'b1;
    if (flush) begin
      ovf_d  = 1'b0;
      perr_d = 1'b0;
    end
  end

  // access edge detectors, captured offset and sticky flags
  always_ff @(posedge CLK) begin
    if (!RST) begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      rsel_q <= REG_DATA;
      ovf_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      rd_q   <= rd_act;
      wr_q   <= wr_act;
      rsel_q <= rsel_d;
      ovf_q  <= ovf_d;
      perr_q <= perr_d;
    end
  end

`ifdef PS2_FIFO_IRQ_EN
  logic irq_en_q, irq_q;
  logic unused_ok;
  assign unused_ok = ^{DIN[7:2], cnt5[4]};
  assign irq_en    = irq_en_q;

  // IRQ enable storage and registered open-drain request
  always_ff @(posedge CLK) begin
    if (!RST) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= DIN[CT_IRQ_EN];
      irq_q <= irq_en_q & ~empty;
    end
  end

  assign INT_N = irq_q ? 1'b0 : 1'bz;
`else
  logic unused_ok;
  assign unused_ok = ^{DIN[7:1], cnt5[4]};
  assign irq_en    = 1'b0;
  assign INT_N     = 1'bz;
`endif

  // count field is 4 bits wide; a 16-deep full FIFO wraps to 0 there
  assign cnt5    = 5'(count);
  assign status  = {cnt5[3:0], perr_q, ovf_q, full, ~empty};
  assign ctrl_rd = {6'b0, irq_en, 1'b0};

  // register read mux, driven only while the CPU is reading
  always_comb begin
    rdata = 8'h00;
    case (reg_sel_e'(REG_SEL))
      REG_DATA:   rdata = empty ? 8'h00 : head;
      REG_STATUS: rdata = status;
      REG_CTRL:   rdata = ctrl_rd;
      default:    rdata = 8'h00;
    endcase
  end

  assign DOUT_EN = rd_act;
  assign DOUT    = rd_act ? rdata : 8'h00;

endmodule

// File: tb/tb_ps2_scancode_fifo.sv
// tb_ps2_scancode_fifo: directed register-level checks of the scan-code FIFO
// at DEPTH_LOG2=4; IRQ checks follow PS2_FIFO_IRQ_EN.
module tb_ps2_scancode_fifo;
  logic       CLK = 1'b0;
  logic       RST, IN_VALID, IN_PERR, CS, RD, WR;
  logic [7:0] IN_DATA, DIN, DOUT;
  logic [1:0] REG_SEL;
  logic       DOUT_EN;
  wire        int_n;
  pullup (int_n);

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  ps2_scancode_fifo #(.DEPTH_LOG2(4)) dut (
    .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
    .IN_PERR(IN_PERR), .CS(CS), .RD(RD), .WR(WR), .REG_SEL(REG_SEL),
    .DIN(DIN), .DOUT(DOUT), .DOUT_EN(DOUT_EN), .INT_N(int_n)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // read access held for ncyc cycles, DOUT checked every cycle; optional
  // receiver strobe in the cycle the access ends
  task automatic rd_chk(input string tag, input logic [1:0] sel, input logic [7:0] exp,
                        input int ncyc = 1, input logic ev = 1'b0, input logic ep = 1'b0,
                        input logic [7:0] ed = 8'h00);
    CS = 1'b1; RD = 1'b0; REG_SEL = sel;
    repeat (ncyc) begin
      #1;
      chk(tag, DOUT, exp);
      @(posedge CLK);
      #1;
    end
    CS = 1'b0; RD = 1'b1;
    IN_VALID = ev; IN_PERR = ep; IN_DATA = ed;
    tick;
    IN_VALID = 1'b0; IN_PERR = 1'b0;
  endtask

  task automatic wr_reg(input logic [1:0] sel, input logic [7:0] val, input int ncyc = 1);
    CS = 1'b1; WR = 1'b0; REG_SEL = sel; DIN = val;
    repeat (ncyc) tick;
    CS = 1'b0; WR = 1'b1;
    tick;
  endtask

  task automatic push(input logic [7:0] b, input logic perr = 1'b0);
    IN_VALID = 1'b1; IN_PERR = perr; IN_DATA = b;
    tick;
    IN_VALID = 1'b0; IN_PERR = 1'b0;
  endtask

  initial begin
    RST = 1'b0; IN_VALID = 1'b0; IN_PERR = 1'b0; IN_DATA = 8'h00;
    CS = 1'b0; RD = 1'b1; WR = 1'b1; REG_SEL = 2'd0; DIN = 8'h00;
    repeat (3) tick;
    chk("rst_dout_en", {7'b0, DOUT_EN}, 8'h00);
    chk("rst_dout", DOUT, 8'h00);
    chk("rst_int_n", {7'b0, int_n}, 8'h01);
    RST = 1'b1;
    tick;

    rd_chk("rst_status", 2'd1, 8'h00);
    rd_chk("rst_data", 2'd0, 8'h00);

    // two bytes, multi-cycle DATA reads pop exactly once each
    push(8'h1C);
    push(8'hF0);
    rd_chk("two_status", 2'd1, 8'h21);
    rd_chk("two_data0", 2'd0, 8'h1C, 3);
    rd_chk("two_data1", 2'd0, 8'hF0, 3);
    rd_chk("two_empty", 2'd1, 8'h00);

    // 17 back-to-back pushes into 16 slots
    IN_VALID = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      IN_DATA = 8'(i);
      tick;
    end
    IN_VALID = 1'b0;
    rd_chk("ovf_status", 2'd1, 8'h07);
    rd_chk("ovf_cleared", 2'd1, 8'h03);
    for (int i = 1; i <= 16; i++) rd_chk("ovf_data", 2'd0, 8'(i));
    rd_chk("ovf_drained", 2'd1, 8'h00);

    // full FIFO: push coincident with a popping read is accepted, no OVF
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    rd_chk("refill_status", 2'd1, 8'h03);
    rd_chk("pp_data", 2'd0, 8'h20, 2, 1'b1, 1'b0, 8'hAA);
    rd_chk("pp_status", 2'd1, 8'h03);
    for (int i = 1; i < 16; i++) rd_chk("pp_data", 2'd0, 8'(8'h20 + i));
    rd_chk("pp_last", 2'd0, 8'hAA);
    rd_chk("pp_drained", 2'd1, 8'h00);

    // pop on empty is ignored
    rd_chk("empty_data", 2'd0, 8'h00);
    rd_chk("empty_status", 2'd1, 8'h00);

    // parity errors: byte discarded, PERR sticky until status read
    push(8'h55, 1'b1);
    rd_chk("perr_status", 2'd1, 8'h08);
    rd_chk("perr_cleared", 2'd1, 8'h00);
    push(8'h55, 1'b1);
    push(8'h33);
    push(8'h44);
    wr_reg(2'd2, 8'h01, 3);
    rd_chk("flush_status", 2'd1, 8'h00);
    rd_chk("flush_data", 2'd0, 8'h00);
    rd_chk("ctrl_read", 2'd2, 8'h00);

    // flag set in the same cycle as its read-clear survives
    rd_chk("setwin_pre", 2'd1, 8'h00, 1, 1'b1, 1'b1, 8'h77);
    rd_chk("setwin_perr", 2'd1, 8'h08);
    rd_chk("setwin_clr", 2'd1, 8'h00);

    // push coincident with FLUSH is discarded
    CS = 1'b1; WR = 1'b0; REG_SEL = 2'd2; DIN = 8'h01;
    IN_VALID = 1'b1; IN_DATA = 8'h66;
    tick;
    IN_VALID = 1'b0;
    tick;
    CS = 1'b0; WR = 1'b1;
    tick;
    rd_chk("flush_push", 2'd1, 8'h00);

    // reserved offset
    push(8'h12);
    wr_reg(2'd3, 8'hFF);
    rd_chk("rsvd_read", 2'd3, 8'h00);
    rd_chk("rsvd_status", 2'd1, 8'h11);

    // reset in the middle of a DATA access: no stray pop afterwards
    CS = 1'b1; RD = 1'b0; REG_SEL = 2'd0;
    tick;
    RST = 1'b0;
    tick;
    CS = 1'b0; RD = 1'b1;
    tick;
    RST = 1'b1;
    tick;
    rd_chk("midrst_status", 2'd1, 8'h00);
    push(8'h5A);
    rd_chk("midrst_push", 2'd1, 8'h11);
    rd_chk("midrst_data", 2'd0, 8'h5A);

`ifdef PS2_FIFO_IRQ_EN
    wr_reg(2'd2, 8'h02);
    rd_chk("irq_ctrl", 2'd2, 8'h02);
    push(8'h29);
    chk("irq_idle", {7'b0, int_n}, 8'h01);
    tick;
    chk("irq_assert", {7'b0, int_n}, 8'h00);
    rd_chk("irq_data", 2'd0, 8'h29);
    chk("irq_hold", {7'b0, int_n}, 8'h00);
    tick;
    chk("irq_release", {7'b0, int_n}, 8'h01);
`else
    wr_reg(2'd2, 8'h02);
    rd_chk("noirq_ctrl", 2'd2, 8'h00);
    push(8'h29);
    tick;
    chk("noirq_int_n", {7'b0, int_n}, 8'h01);
    rd_chk("noirq_data", 2'd0, 8'h29);
    tick;
    chk("noirq_int_n2", {7'b0, int_n}, 8'h01);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_fifo.md
Name: ps2_scancode_fifo

Overview:
- Downstream stage of the CPLD PS/2 receiver.
- Accepts completed scan-code bytes from the deserializer and buffers them in a small FIFO so the CPU cannot lose keystrokes between polls.
- Exposes data/status/control registers inside the CPLD I/O window (0x4000 region, selected by the address decoder), plus an optional interrupt request.

Parameters:
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries; legal range 2..4.

Ports:
- CLK  input  1  system clock (CPU clock).
- RST  input  1  synchronous reset, active-low.
- IN_DATA  input  8  scan-code byte from PS/2 receiver.
- IN_VALID  input  1  one-CLK strobe: IN_DATA/IN_PERR valid.
- IN_PERR  input  1  parity/framing error for the byte in this strobe.
- CS  input  1  active-high register-block select from decoder (IOREQ already qualified).
- RD  input  1  CPU read strobe, active-low.
- WR  input  1  CPU write strobe, active-low.
- REG_SEL  input  2  register offset (ADDR[1:0]).
- DIN  input  8  CPU write data.
- DOUT  output  8  register read data.
- DOUT_EN  output  1  high while DOUT must drive the data bus (CS & ~RD).
- INT_N  output  1  interrupt request, open-drain style (0 or Z).

Behaviour:
- Register map:
  - Offset 0 DATA (R): head byte. Returns 0x00 when empty.
  - Offset 1 STATUS (R): bit0 RXRDY (not empty), bit1 FULL, bit2 OVF sticky, bit3 PERR sticky, bits7:4 count[3:0]. At depth 16 a full FIFO reports count field 0 with FULL=1.
  - Offset 2 CTRL (R/W): bit0 FLUSH (write-1, self-clearing, reads 0), bit1 IRQ_EN.
  - Offset 3: reads 0x00; writes ignored.
- Reset (RST=0 at posedge CLK): FIFO empty, count 0, OVF=0, PERR=0, IRQ_EN=0, DOUT=0, DOUT_EN=0, INT_N=Z. Reset mid-access discards any pending pop or write.
- Access edge detection:
  - One registered copy each of (CS&~RD) and (CS&~WR).
  - Pop occurs on the first cycle the read term is low after being high (end of access), and only if that access addressed offset 0 and the FIFO is non-empty.
  - Status read-clear of OVF/PERR happens at the same end-of-access point for offset 1.
  - CTRL write applies on the first cycle (CS&~WR) is seen high; a multi-cycle write strobe produces exactly one write.
- DOUT is combinational from head/status while DOUT_EN is high; DATA reads show the same byte for the whole access.
- Push: IN_VALID & ~IN_PERR stores IN_DATA; count and RXRDY update on the next cycle (1-cycle latency).
- IN_VALID & IN_PERR: byte discarded, PERR set.
- Push while full with no pop in the same cycle: byte dropped, OVF set, contents unchanged.
- Push and pop in the same cycle: both performed; count unchanged; no OVF, even when full. Pop on empty: ignored.
- Same-cycle flag set and read-clear: set wins.
- FLUSH: pointers and count to 0, OVF and PERR cleared, IRQ_EN takes the written bit1. A push coincident with FLUSH is discarded.
- Pointers wrap modulo depth. Count width is DEPTH_LOG2+1.

Optional Feature:
- PS2_FIFO_IRQ_EN defined:
  - INT_N registered; driven 0 the cycle after (IRQ_EN & RXRDY) becomes true, Z otherwise.
  - Deasserts the cycle after the FIFO goes empty or IRQ_EN clears.
- Not defined:
  - INT_N constantly Z.
  - CTRL bit1 is not stored and reads 0.
  - No interrupt logic synthesized.

Decomposition:
- Package ps2_fifo_pkg:
  - Register offset constants (DATA=0, STATUS=1, CTRL=2).
  - STATUS bit positions (RXRDY, FULL, OVF, PERR, count field LSB=4).
  - CTRL bit positions (FLUSH=0, IRQ_EN=1).
- One sub-module, byte_sync_fifo:
  - Storage, read/write pointers, count, full/empty, simultaneous push/pop, flush.
  - Parameterised by DEPTH_LOG2.
- Top level holds the CPU register interface, edge detection, sticky flags and IRQ.

Test Plan:
- Reset, then read STATUS -> 0x00; read DATA -> 0x00; INT_N=Z.
- Push 0x1C, then 0xF0 (one strobe each); 3-cycle RD access to DATA twice -> 0x1C then 0xF0, each popped once; STATUS then 0x00.
- Push 17 bytes 0x01..0x11 with DEPTH_LOG2=4 -> STATUS 0x07 (FULL, OVF, RXRDY); 16 DATA reads return 0x01..0x10. The STATUS read clears OVF -> next STATUS 0x03.
- With FIFO full, assert IN_VALID=0xAA in the same cycle a DATA access ends -> count stays 16, OVF=0, last read byte is 0xAA.
- IN_VALID with IN_PERR=1, data 0x55 -> count 0, STATUS 0x08; write CTRL 0x01 -> STATUS 0x00.
- With PS2_FIFO_IRQ_EN: write CTRL 0x02, push 0x29 -> INT_N=0 next cycle. Read DATA -> INT_N=Z the cycle after the pop. Without the macro, INT_N stays Z throughout.
